fifo_stream_adapter: RTL and testbench

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

---
 rtl/fifo_stream_adapter_pkg.sv | 25 ++
 rtl/skid_buf2.sv | 65 ++++++
 rtl/fifo_stream_adapter.sv | 76 +++++++
 tb/tb_fifo_stream_adapter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_adapter_pkg.sv
// fifo_stream_adapter_pkg
// Shared constants and helpers for the FIFO-to-stream adapter.
//   DATA_WIDTH_DEF : default data word width
//   BUF_DEPTH      : depth of the ordered output buffer (2)
//   OCC_WIDTH      : width of the occupancy count (holds 0..2)
package fifo_stream_adapter_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int BUF_DEPTH      = 2;
  localparam int OCC_WIDTH      = 2;

  typedef logic [OCC_WIDTH-1:0] occ_t;

  // True when one more read can be issued without the buffer ever holding
  // more than BUF_DEPTH words: words already held plus the word in flight,
  // minus the word leaving this cycle, must stay below the depth.
  function automatic logic can_issue(input occ_t occ, input logic inflight,
                                     input logic pop);
    logic [OCC_WIDTH:0] committed;
    committed = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight}
              - {{OCC_WIDTH{1'b0}}, pop};
    return committed < (OCC_WIDTH+1)'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// skid_buf2
// Two-entry ordered buffer. entry0 is always the oldest word and drives head.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (count and entries to 0)
//   clear : synchronous discard of all held words (entries keep stale data)
//   push  : write din at the tail this cycle
//   pop   : remove the head word this cycle
//   din   : tail write data
//   head  : oldest held word
//   count : number of held words (0..2)
// The caller guarantees no push when full and no pop when empty.
module skid_buf2
  import fifo_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  count
);

  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == '0) entry0 <= din;
          else             entry1 <= din;
          count <= count + 1'b1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 1'b1;
        end
        2'b11: begin
          // Count unchanged; new word lands behind whatever remains.
          if (count == OCC_WIDTH'(1)) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
// Turns an upstream FIFO with registered read data (data one cycle after the
// read strobe) into a valid/ready stream, buffering up to two words.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   fifo_empty : upstream FIFO empty flag
//   fifo_data  : upstream read data, valid the cycle after an accepted read
//   fifo_r_en  : upstream read strobe
//   m_valid    : stream data valid
//   m_data     : stream data (oldest buffered word)
//   m_ready    : downstream ready
//   flush      : discard buffered and in-flight words
//   occupancy  : words held in the buffer (0..2)
//   xfer_count : completed stream transfers, wraps, not cleared by flush
//
// Handshake: a transfer happens on every cycle with m_valid & m_ready. While
// m_valid is high and m_ready low, m_valid and m_data hold. m_valid never
// depends on m_ready; fifo_r_en does (a pop frees a slot in the same cycle).
module fifo_stream_adapter
  import fifo_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output occ_t                  occupancy,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  logic inflight;
  logic pop;
  logic push;
  occ_t count;

  assign m_valid   = ~rst & (count != '0);
  assign pop       = m_valid & m_ready;
  // A word arriving in a flush cycle is dropped rather than buffered.
  assign push      = inflight & ~flush;
  assign fifo_r_en = ~rst & ~flush & ~fifo_empty & can_issue(count, inflight, pop);

  always_ff @(posedge clk) begin
    if (rst || flush) inflight <= 1'b0;
    else              inflight <= fifo_r_en & ~fifo_empty;
  end

  // A pop in a flush cycle was seen by the consumer, so it still counts.
  always_ff @(posedge clk) begin
    if (rst)      xfer_count <= '0;
    else if (pop) xfer_count <= xfer_count + 1'b1;
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .clear(flush),
    .push (push),
    .pop  (pop),
    .din  (fifo_data),
    .head (m_data),
    .count(count)
  );

  assign occupancy = count;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter
// Directed bench for fifo_stream_adapter: a per-cycle vector table for the
// basic fill/drain and backpressure cases, then hand-written sequences for
// continuous streaming, flush, counter wrap and mid-stream reset.
module tb_fifo_stream_adapter;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         fifo_empty;
  logic [W-1:0] fifo_data;
  logic         fifo_r_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
  logic         flush;
  logic [1:0]   occupancy;
  logic [15:0]  xfer_count;

  fifo_stream_adapter #(
    .DATA_WIDTH(W),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .flush     (flush),
    .occupancy (occupancy),
    .xfer_count(xfer_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- upstream FIFO model + scoreboard ----------------
  logic [W-1:0] fq[$];     // words still in the upstream FIFO
  logic [W-1:0] exp_q[$];  // expected stream order
  bit           inf_mode;  // endless FIFO producing an incrementing count
  logic [W-1:0] inf_ctr;

  int checks;
  int failures;

  typedef struct {
    int         ld_n;
    logic [W-1:0] ld_base;
    logic [W-1:0] ld_step;
    logic       rst;
    logic       flush;
    logic       rdy;
    logic       chk_data;
    logic       e_ren;
    logic       e_valid;
    logic [W-1:0] e_data;
    logic [1:0] e_occ;
    logic [15:0] e_xfer;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int ld_n, logic [W-1:0] ld_base, logic [W-1:0] ld_step,
                              logic r, logic f, logic rdy, logic cd, logic ren,
                              logic val, logic [W-1:0] d, logic [1:0] occ,
                              logic [15:0] x);
    vec_t v;
    v.ld_n = ld_n; v.ld_base = ld_base; v.ld_step = ld_step;
    v.rst = r; v.flush = f; v.rdy = rdy; v.chk_data = cd;
    v.e_ren = ren; v.e_valid = val; v.e_data = d; v.e_occ = occ; v.e_xfer = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock. The read strobe is sampled just before the edge; the
  // FIFO model then presents the read word (registered read) after the edge.
  task automatic tick();
    logic rd;
    rd = fifo_r_en;
    @(posedge clk);
    #1;
    if (rd) begin
      if (inf_mode) begin
        fifo_data = inf_ctr;
        inf_ctr   = inf_ctr + 1'b1;
      end else if (fq.size() > 0) begin
        fifo_data = fq.pop_front();
      end
    end
    fifo_empty = inf_mode ? 1'b0 : (fq.size() == 0);
  endtask

  task automatic load(input logic [W-1:0] base, input logic [W-1:0] step, input int n);
    for (int k = 0; k < n; k++) fq.push_back(base + W'(k) * step);
    if (n > 0) fifo_empty = 1'b0;
  endtask

  initial begin
    int n;
    int first_c;
    int last_c;

    checks = 0; failures = 0;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0;
    inf_mode = 1'b0; inf_ctr = '0;

    // ---------------- reset ----------------
    #1;
    tick();
    tick();

    // ---------------- vector table ----------------
    // Preload 0x11,0x22,0x33 during reset, drain with m_ready high.
    tv.push_back(mk(3, 16'h0011, 16'h0011, 1, 0, 1, 1, 0, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 16'h0000, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 16'h0011, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h0022, 1, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h0033, 1, 2));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 3));
    // Four words, m_ready low for ten cycles: two reads, then hold.
    tv.push_back(mk(4, 16'h00A1, 16'h0001, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 16'h0000, 0, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h00A1, 1, 3));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h00A1, 2, 3));
    // Release backpressure: remaining words in order.
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 16'h00A1, 2, 3));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 16'h00A2, 1, 4));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h00A3, 1, 5));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 16'h00A4, 1, 6));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 16'h0000, 0, 7));

    for (int i = 0; i < tv.size(); i++) begin
      load(tv[i].ld_base, tv[i].ld_step, tv[i].ld_n);
      rst = tv[i].rst; flush = tv[i].flush; m_ready = tv[i].rdy;
      #2;
      chk($sformatf("vec%0d_r_en", i), 32'(fifo_r_en), 32'(tv[i].e_ren));
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(tv[i].e_valid));
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(tv[i].e_occ));
      chk($sformatf("vec%0d_xfer", i), 32'(xfer_count), 32'(tv[i].e_xfer));
      if (tv[i].chk_data)
        chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(tv[i].e_data));
      tick();
    end

    // ---------------- continuous stream 0x0100..0x010F ----------------
    load(16'h0100, 16'h0001, 16);
    for (int k = 0; k < 16; k++) exp_q.push_back(16'h0100 + W'(k));
    m_ready = 1'b1;
    n = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (m_valid) begin
        if (first_c < 0) first_c = c;
        last_c = c;
        n++;
        if (exp_q.size() == 0) chk("stream_extra_word", 32'(m_data), 32'hFFFF_FFFF);
        else                   chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      tick();
    end
    chk("stream_first_cycle", 32'(first_c), 32'd2);
    chk("stream_count", 32'(n), 32'd16);
    chk("stream_span", 32'(last_c - first_c), 32'd15);
    chk("stream_xfer", 32'(xfer_count), 32'd23);

    // ---------------- flush with a buffered and an in-flight word ----------------
    exp_q.delete();
    load(16'h0200, 16'h0001, 4);
    m_ready = 1'b0;
    #2;
    chk("flush_setup_r_en", 32'(fifo_r_en), 32'd1);
    tick();
    #2;
    tick();
    flush = 1'b1; m_ready = 1'b1;
    #2;
    chk("flush_cycle_occ", 32'(occupancy), 32'd1);
    chk("flush_cycle_valid", 32'(m_valid), 32'd1);
    chk("flush_cycle_data", 32'(m_data), 32'h0200);
    chk("flush_cycle_r_en", 32'(fifo_r_en), 32'd0);
    tick();
    flush = 1'b0;
    #2;
    chk("flush_after_valid", 32'(m_valid), 32'd0);
    chk("flush_after_occ", 32'(occupancy), 32'd0);
    chk("flush_after_xfer", 32'(xfer_count), 32'd24);
    exp_q.push_back(16'h0202);
    exp_q.push_back(16'h0203);
    tick();
    for (int c = 0; c < 10; c++) begin
      #2;
      if (m_valid) begin
        if (exp_q.size() == 0) chk("flush_extra_word", 32'(m_data), 32'hFFFF_FFFF);
        else                   chk("flush_resume_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      tick();
    end
    chk("flush_resume_left", 32'(exp_q.size()), 32'd0);
    chk("flush_resume_xfer", 32'(xfer_count), 32'd26);

    // ---------------- transfer counter wrap ----------------
    rst = 1'b1; m_ready = 1'b0;
    #2;
    tick();
    rst = 1'b0;
    inf_mode = 1'b1; inf_ctr = '0; fifo_empty = 1'b0;
    m_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 70000 && n < 65535; c++) begin
      #2;
      if (m_valid) n++;
      tick();
    end
    chk("wrap_budget", 32'(n), 32'd65535);
    m_ready = 1'b0;
    #2;
    tick();
    #2;
    tick();
    #2;
    chk("wrap_full_count", 32'(xfer_count), 32'hFFFF);
    chk("wrap_hold_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    #2;
    tick();

    // ---------------- reset mid-stream (occupancy 1, one word in flight) ----------------
    rst = 1'b1;
    #2;
    chk("wrap_zero", 32'(xfer_count), 32'h0000);
    chk("rst_pre_occ", 32'(occupancy), 32'd1);
    chk("rst_comb_valid", 32'(m_valid), 32'd0);
    chk("rst_comb_r_en", 32'(fifo_r_en), 32'd0);
    // Upstream FIFO is reset alongside.
    inf_mode = 1'b0;
    fq.delete();
    fifo_empty = 1'b1;
    tick();
    #2;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_xfer", 32'(xfer_count), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_r_en", 32'(fifo_r_en), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("rst_inflight_dropped", 32'(m_valid), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
